// File: rtl/adpll_cfg_loader_if.sv
// Command bus between the host logic and the ADPLL configuration loader.
// The host side drives a valid/ready command handshake and presents the
// shadow configuration values used by the load-all commands.
interface adpll_cfg_loader_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_sel;
  logic [4:0] cmd_data;
  logic [3:0] cfg_ndiv;
  logic [4:0] cfg_alpha;
  logic [4:0] cfg_beta;
  logic [4:0] cfg_dco_offset;
  logic [4:0] cfg_dco_thresh;
  logic [4:0] cfg_kdco;

  modport master (
    output cmd_valid, cmd_op, cmd_sel, cmd_data,
    output cfg_ndiv, cfg_alpha, cfg_beta, cfg_dco_offset, cfg_dco_thresh, cfg_kdco,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_sel, cmd_data,
    input  cfg_ndiv, cfg_alpha, cfg_beta, cfg_dco_offset, cfg_dco_thresh, cfg_kdco,
    output cmd_ready
  );
endinterface

// File: rtl/adpll_cfg_loader.sv
// ADPLL programming-interface sequencer.
// Accepts write-single, clear, load-all and clear-then-load-all commands and
// drives the chip pins clr / program / param_sel / pgm_value with glitch-free,
// fully registered timing: sel/value settle for SETUP_CYC cycles before the
// program strobe and stay put for HOLD_CYC cycles after it.
// The chip "program" pin is named prog here because program is a reserved
// SystemVerilog keyword.
// Optional build macro ADPLL_CFG_READBACK_EN adds a per-parameter mirror of
// the last value written, readable through rd_sel / rd_data.
module adpll_cfg_loader #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 2,
  parameter int unsigned CLR_CYC    = 2
) (
  input  logic                clk,
  input  logic                rst,
  adpll_cfg_loader_if.slave   bus,
  output logic                clr,
  output logic                prog,
  output logic [2:0]          param_sel,
  output logic [4:0]          pgm_value,
  output logic                pgm_oe,
  output logic                busy,
  output logic                done,
  output logic                err
`ifdef ADPLL_CFG_READBACK_EN
  ,
  input  logic [2:0]          rd_sel,
  output logic [4:0]          rd_data
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_CLR_GAP,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_t;

  typedef enum logic [1:0] {
    OP_WRITE    = 2'd0,
    OP_CLEAR    = 2'd1,
    OP_LOAD     = 2'd2,
    OP_CLR_LOAD = 2'd3
  } op_t;

  localparam logic [2:0] SEL_LAST = 3'd5;

  // Counter reload values: a state lasts (load + 1) cycles; 0 behaves as 1.
  localparam logic [3:0] SETUP_LD  = (SETUP_CYC  > 1) ? 4'(SETUP_CYC  - 1) : 4'd0;
  localparam logic [3:0] STROBE_LD = (STROBE_CYC > 1) ? 4'(STROBE_CYC - 1) : 4'd0;
  localparam logic [3:0] HOLD_LD   = (HOLD_CYC   > 1) ? 4'(HOLD_CYC   - 1) : 4'd0;
  localparam logic [3:0] CLR_LD    = (CLR_CYC    > 1) ? 4'(CLR_CYC    - 1) : 4'd0;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       load_all_q, load_all_d;
  logic       ready_q, ready_d;
  logic [4:0] snap_q [6];
  logic       accept;

  logic       clr_d, prog_d, oe_d, busy_d, done_d, err_d;
  logic [2:0] sel_d;
  logic [4:0] value_d;

  // Ready is a registered IDLE flag, forced low while reset is held.
  assign bus.cmd_ready = ready_q & ~rst;
  assign accept        = bus.cmd_valid & bus.cmd_ready;

  // Next-state, counter and registered-output decode.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_all_d = load_all_q;
    sel_d      = param_sel;
    value_d    = pgm_value;
    done_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (op_t'(bus.cmd_op))
            OP_WRITE: begin
              if (bus.cmd_sel > SEL_LAST) begin
                err_d = 1'b1;
              end else begin
                state_d    = S_SETUP;
                cnt_d      = SETUP_LD;
                load_all_d = 1'b0;
                sel_d      = bus.cmd_sel;
                // ndiv is only four bits wide on the chip side.
                value_d    = (bus.cmd_sel == 3'd0) ? {1'b0, bus.cmd_data[3:0]} : bus.cmd_data;
              end
            end
            OP_CLEAR: begin
              state_d    = S_CLR;
              cnt_d      = CLR_LD;
              load_all_d = 1'b0;
            end
            OP_LOAD: begin
              state_d    = S_SETUP;
              cnt_d      = SETUP_LD;
              load_all_d = 1'b1;
              sel_d      = 3'd0;
              value_d    = {1'b0, bus.cfg_ndiv};
            end
            OP_CLR_LOAD: begin
              state_d    = S_CLR;
              cnt_d      = CLR_LD;
              load_all_d = 1'b1;
            end
            default: ;
          endcase
        end
      end

      S_CLR: begin
        if (cnt_q == 4'd0) begin
          state_d = S_CLR_GAP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      // One idle cycle with clr low so clr never overlaps a strobe.
      S_CLR_GAP: begin
        if (load_all_q) begin
          state_d = S_SETUP;
          cnt_d   = SETUP_LD;
          sel_d   = 3'd0;
          value_d = snap_q[0];
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end

      S_SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = S_STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      // End of a triplet: either start the next parameter or finish.
      S_HOLD: begin
        if (cnt_q == 4'd0) begin
          if (load_all_q && (param_sel != SEL_LAST)) begin
            state_d = S_SETUP;
            cnt_d   = SETUP_LD;
            sel_d   = param_sel + 3'd1;
            value_d = snap_q[param_sel + 3'd1];
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Pin levels follow the state being entered, so they come straight off flops.
    clr_d   = (state_d == S_CLR);
    prog_d  = (state_d == S_STROBE);
    oe_d    = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
  end

  // State, counter and output registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      load_all_q <= 1'b0;
      ready_q    <= 1'b1;
      clr        <= 1'b0;
      prog       <= 1'b0;
      param_sel  <= 3'd0;
      pgm_value  <= 5'd0;
      pgm_oe     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      load_all_q <= load_all_d;
      ready_q    <= ready_d;
      clr        <= clr_d;
      prog       <= prog_d;
      param_sel  <= sel_d;
      pgm_value  <= value_d;
      pgm_oe     <= oe_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

  // Snapshot of the shadow values taken at accept.
  // NOTE: the snapshot is data-only storage and is never read before an accept
  // writes it, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      snap_q[0] <= {1'b0, bus.cfg_ndiv};
      snap_q[1] <= bus.cfg_alpha;
      snap_q[2] <= bus.cfg_beta;
      snap_q[3] <= bus.cfg_dco_offset;
      snap_q[4] <= bus.cfg_dco_thresh;
      snap_q[5] <= bus.cfg_kdco;
    end
  end

`ifdef ADPLL_CFG_READBACK_EN
  logic [4:0] mirror_q [6];

  // Mirror of the value last written to each chip register.
  always_ff @(posedge clk) begin
    if (rst || (state_q == S_CLR_GAP)) begin
      for (int i = 0; i < 6; i++) mirror_q[i] <= 5'd0;
    end else if ((state_q == S_HOLD) && (cnt_q == 4'd0)) begin
      mirror_q[param_sel] <= pgm_value;
    end
  end

  // Combinational read port; unused selects read as zero.
  always_comb begin
    rd_data = 5'd0;
    if (rd_sel <= SEL_LAST) rd_data = mirror_q[rd_sel];
  end
`endif

endmodule

// File: tb/tb_adpll_cfg_loader.sv
// Self-checking bench for adpll_cfg_loader at default timing (2/2/2/2).
// Vector table of commands with hand-derived completion cycles, plus
// directed sequences for reset mid-strobe, back-to-back accept and (with
// ADPLL_CFG_READBACK_EN) the readback mirrors.
module tb_adpll_cfg_loader;
  localparam int S = 2;
  localparam int P = 2;
  localparam int H = 2;
  localparam int C = 2;
  localparam int T = S + P + H;
  localparam int NV = 9;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr, prog, pgm_oe, busy, done, err;
  logic [2:0] param_sel;
  logic [4:0] pgm_value;
`ifdef ADPLL_CFG_READBACK_EN
  logic [2:0] rd_sel = 3'd0;
  logic [4:0] rd_data;
`endif

  adpll_cfg_loader_if bus ();

  adpll_cfg_loader #(
    .SETUP_CYC (S),
    .STROBE_CYC(P),
    .HOLD_CYC  (H),
    .CLR_CYC   (C)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .clr      (clr),
    .prog     (prog),
    .param_sel(param_sel),
    .pgm_value(pgm_value),
    .pgm_oe   (pgm_oe),
    .busy     (busy),
    .done     (done),
    .err      (err)
`ifdef ADPLL_CFG_READBACK_EN
    ,
    .rd_sel   (rd_sel),
    .rd_data  (rd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [2:0] sel;
    logic [4:0] data;
    logic [2:0] exp_sel;
    logic [4:0] exp_val;
    logic       exp_err;
    int         exp_done;
  } vec_t;

  vec_t vecs [NV];
  logic [4:0] exp_cfg [6];

  int n_tests = 0;
  int n_fail  = 0;

  // Per-cycle trace of one command, cycle 1 = first cycle after accept edge.
  logic [127:0] m_prog, m_oe, m_clr, m_busy, m_done, m_err, m_ready;
  logic [2:0]   t_sel [128];
  logic [4:0]   t_val [128];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] span(input int lo, input int hi);
    logic [127:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Reference timing model: pin masks for one command accepted at edge 0.
  task automatic model(input logic [1:0] op, input logic is_err,
                       output logic [127:0] p, output logic [127:0] oe,
                       output logic [127:0] cl, output logic [127:0] bz,
                       output int ntrip, output int base, output int last);
    p = '0; oe = '0; cl = '0; bz = '0; ntrip = 0; base = 1; last = 0;
    if (!is_err) begin
      if (op == 2'd1 || op == 2'd3) begin
        cl   = span(1, C);
        base = C + 2;
      end
      ntrip = (op == 2'd0) ? 1 : (op == 2'd1) ? 0 : 6;
      for (int t = 0; t < ntrip; t++) begin
        oe |= span(base + t * T, base + t * T + T - 1);
        p  |= span(base + t * T + S, base + t * T + S + P - 1);
      end
      last = base + ntrip * T;
      bz   = span(1, last - 1);
    end
  endtask

  task automatic drive_cfg();
    bus.cfg_ndiv       = exp_cfg[0][3:0];
    bus.cfg_alpha      = exp_cfg[1];
    bus.cfg_beta       = exp_cfg[2];
    bus.cfg_dco_offset = exp_cfg[3];
    bus.cfg_dco_thresh = exp_cfg[4];
    bus.cfg_kdco       = exp_cfg[5];
  endtask

  task automatic scramble_cfg();
    bus.cfg_ndiv       = ~exp_cfg[0][3:0];
    bus.cfg_alpha      = ~exp_cfg[1];
    bus.cfg_beta       = ~exp_cfg[2];
    bus.cfg_dco_offset = ~exp_cfg[3];
    bus.cfg_dco_thresh = ~exp_cfg[4];
    bus.cfg_kdco       = ~exp_cfg[5];
  endtask

  // Called at a negedge; presents a command and returns just after its accept edge.
  task automatic issue(input logic [1:0] op, input logic [2:0] sel, input logic [4:0] data);
    int w = 0;
    while (bus.cmd_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("issue_ready", 128'(bus.cmd_ready), 128'(1));
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_sel   = sel;
    bus.cmd_data  = data;
    drive_cfg();
    @(posedge clk);
  endtask

  // Records pins each negedge until n_stop done pulses or an err pulse.
  task automatic trace(input int n_stop, input logic hold_valid,
                       input logic [2:0] sel2, input logic [4:0] data2);
    int n_done   = 0;
    int done_cyc = 0;
    m_prog = '0; m_oe = '0; m_clr = '0; m_busy = '0; m_done = '0; m_err = '0; m_ready = '0;
    for (int c = 1; c < 128; c++) begin
      @(negedge clk);
      m_prog[c]  = prog;
      m_oe[c]    = pgm_oe;
      m_clr[c]   = clr;
      m_busy[c]  = busy;
      m_done[c]  = done;
      m_err[c]   = err;
      m_ready[c] = bus.cmd_ready;
      t_sel[c]   = param_sel;
      t_val[c]   = pgm_value;
      if (c == 1) begin
        scramble_cfg();
        if (hold_valid) begin
          bus.cmd_sel  = sel2;
          bus.cmd_data = data2;
        end else begin
          bus.cmd_valid = 1'b0;
        end
      end
      if (done === 1'b1) begin
        n_done++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (hold_valid && done_cyc != 0 && c > done_cyc) bus.cmd_valid = 1'b0;
      if (n_done >= n_stop || err === 1'b1) break;
    end
    bus.cmd_valid = 1'b0;
  endtask

  // Watchdog so a stuck DUT cannot hang the run.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ep, eoe, ecl, ebz;
    int ntrip, base, last, nbad;

    exp_cfg[0] = 5'h0A; exp_cfg[1] = 5'd3; exp_cfg[2] = 5'd4;
    exp_cfg[3] = 5'd5;  exp_cfg[4] = 5'd6; exp_cfg[5] = 5'd7;

    //          op    sel   data   esel  eval   err   done
    vecs[0] = '{2'd0, 3'd1, 5'h15, 3'd1, 5'h15, 1'b0, 7};
    vecs[1] = '{2'd0, 3'd0, 5'h1F, 3'd0, 5'h0F, 1'b0, 7};
    vecs[2] = '{2'd0, 3'd5, 5'h0A, 3'd5, 5'h0A, 1'b0, 7};
    vecs[3] = '{2'd0, 3'd6, 5'h01, 3'd0, 5'h00, 1'b1, 0};
    vecs[4] = '{2'd0, 3'd7, 5'h1F, 3'd0, 5'h00, 1'b1, 0};
    vecs[5] = '{2'd1, 3'd0, 5'h00, 3'd0, 5'h00, 1'b0, 4};
    vecs[6] = '{2'd2, 3'd0, 5'h00, 3'd0, 5'h00, 1'b0, 37};
    vecs[7] = '{2'd3, 3'd0, 5'h00, 3'd0, 5'h00, 1'b0, 40};
    vecs[8] = '{2'd0, 3'd4, 5'h1E, 3'd4, 5'h1E, 1'b0, 7};

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_sel   = 3'd0;
    bus.cmd_data  = 5'd0;
    drive_cfg();

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready_low", 128'(bus.cmd_ready), 128'(0));
    check("rst_pins", 128'({clr, prog, pgm_oe, busy, done, err}), 128'(0));
    check("rst_sel_val", 128'({param_sel, pgm_value}), 128'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready_after", 128'(bus.cmd_ready), 128'(1));

    // Table-driven commands.
    for (int i = 0; i < NV; i++) begin
      model(vecs[i].op, vecs[i].exp_err, ep, eoe, ecl, ebz, ntrip, base, last);
      issue(vecs[i].op, vecs[i].sel, vecs[i].data);
      trace(1, 1'b0, 3'd0, 5'd0);
      check($sformatf("v%0d_prog", i), m_prog, ep);
      check($sformatf("v%0d_oe", i), m_oe, eoe);
      check($sformatf("v%0d_clr", i), m_clr, ecl);
      check($sformatf("v%0d_busy", i), m_busy, ebz);
      check($sformatf("v%0d_err", i), m_err, vecs[i].exp_err ? span(1, 1) : '0);
      check($sformatf("v%0d_done", i), m_done,
            (vecs[i].exp_done != 0) ? span(vecs[i].exp_done, vecs[i].exp_done) : '0);
      check($sformatf("v%0d_ready", i), m_ready,
            vecs[i].exp_err ? span(1, 1) : span(last, last));
      for (int t = 0; t < ntrip; t++) begin
        nbad = 0;
        for (int c = base + t * T; c < base + (t + 1) * T; c++) begin
          if (vecs[i].op == 2'd0) begin
            if (t_sel[c] !== vecs[i].exp_sel || t_val[c] !== vecs[i].exp_val) nbad++;
          end else begin
            if (t_sel[c] !== 3'(t) || t_val[c] !== exp_cfg[t]) nbad++;
          end
        end
        check($sformatf("v%0d_trip%0d_selval_bad_cycles", i, t), 128'(nbad), 128'(0));
      end
    end

    // Reset while program is high, then a fresh command on the next edge.
    issue(2'd0, 3'd3, 5'h1C);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstmid_prog_before", 128'(prog), 128'(1));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rstmid_pins", 128'({clr, prog, pgm_oe, busy, done}), 128'(0));
    check("rstmid_sel", 128'(param_sel), 128'(0));
    check("rstmid_ready", 128'(bus.cmd_ready), 128'(1));
    issue(2'd0, 3'd2, 5'h09);
    trace(1, 1'b0, 3'd0, 5'd0);
    check("rstmid_next_prog", m_prog, span(3, 4));
    check("rstmid_next_done", m_done, span(7, 7));
    check("rstmid_next_selval", 128'({t_sel[3], t_val[3]}), 128'({3'd2, 5'h09}));

    // Back-to-back: cmd_valid held, fields change after the first accept.
    // Low gap between pulses = HOLD + done cycle + SETUP.
    issue(2'd0, 3'd1, 5'h11);
    trace(2, 1'b1, 3'd4, 5'h02);
    check("b2b_prog", m_prog, span(3, 4) | span(10, 11));
    check("b2b_done", m_done, span(7, 7) | span(14, 14));
    check("b2b_busy", m_busy, span(1, 6) | span(8, 13));
    check("b2b_first", 128'({t_sel[3], t_val[3]}), 128'({3'd1, 5'h11}));
    check("b2b_second", 128'({t_sel[10], t_val[10]}), 128'({3'd4, 5'h02}));

`ifdef ADPLL_CFG_READBACK_EN
    // Mirrors after load-all, then cleared by op 1.
    issue(2'd2, 3'd0, 5'd0);
    trace(1, 1'b0, 3'd0, 5'd0);
    rd_sel = 3'd5;
    #1 check("rb_kdco", 128'(rd_data), 128'(exp_cfg[5]));
    rd_sel = 3'd0;
    #1 check("rb_ndiv", 128'(rd_data), 128'(exp_cfg[0]));
    rd_sel = 3'd6;
    #1 check("rb_sel6", 128'(rd_data), 128'(0));
    issue(2'd1, 3'd0, 5'd0);
    trace(1, 1'b0, 3'd0, 5'd0);
    rd_sel = 3'd5;
    #1 check("rb_after_clear", 128'(rd_data), 128'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
